// File: rtl/iter_alu.sv
// iter_alu: execute-stage ALU behind a valid/ready handshake.
// Logic, add/sub and shift operations finish in one cycle. MULT and DIV are
// iterative and resolve one bit per cycle. While an operation is in flight,
// in_ready stays low. Results are held until the consumer takes them.
module iter_alu #(
    parameter int WIDTH   = 32,
    parameter int CMD_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CMD_LEN-1:0] cmd,
    input  logic [WIDTH-1:0]   val1,
    input  logic [WIDTH-1:0]   val2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               div_by_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [CMD_LEN-1:0] CMD_ADD  = CMD_LEN'(0);
    localparam logic [CMD_LEN-1:0] CMD_SUB  = CMD_LEN'(1);
    localparam logic [CMD_LEN-1:0] CMD_AND  = CMD_LEN'(2);
    localparam logic [CMD_LEN-1:0] CMD_OR   = CMD_LEN'(3);
    localparam logic [CMD_LEN-1:0] CMD_NOR  = CMD_LEN'(4);
    localparam logic [CMD_LEN-1:0] CMD_XOR  = CMD_LEN'(5);
    localparam logic [CMD_LEN-1:0] CMD_SLL  = CMD_LEN'(6);
    localparam logic [CMD_LEN-1:0] CMD_SRL  = CMD_LEN'(7);
    localparam logic [CMD_LEN-1:0] CMD_SRA  = CMD_LEN'(8);
    localparam logic [CMD_LEN-1:0] CMD_MULT = CMD_LEN'(9);
    localparam logic [CMD_LEN-1:0] CMD_DIV  = CMD_LEN'(10);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic             isDiv_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] resultHi_q;
    logic             dbz_q;
    logic             outValid_q;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] aluRes;
    logic             isMulCmd;
    logic             isDivCmd;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divFits;
    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = outValid_q;
    assign result      = result_q;
    assign result_hi   = resultHi_q;
    assign div_by_zero = dbz_q;

    assign isMulCmd = (cmd == CMD_MULT);
    assign isDivCmd = (cmd == CMD_DIV);

    // Single-cycle datapath, evaluated straight from the live operands at accept.
    always_comb begin
        shamt  = val2[SHW-1:0];
        aluRes = '0;
        case (cmd)
            CMD_ADD: aluRes = val1 + val2;
            CMD_SUB: aluRes = val1 - val2;
            CMD_AND: aluRes = val1 & val2;
            CMD_OR:  aluRes = val1 | val2;
            CMD_NOR: aluRes = ~(val1 | val2);
            CMD_XOR: aluRes = val1 ^ val2;
            CMD_SLL: aluRes = val1 << shamt;
            CMD_SRL: aluRes = val1 >> shamt;
            CMD_SRA: aluRes = WIDTH'($signed(val1) >>> shamt);
            default: aluRes = '0;
        endcase
    end

    // One iteration step: shift-add for MULT, restoring shift-subtract for DIV.
    // For DIV the partial remainder stays below the divisor, so the borrow bit
    // of the trial subtraction alone tells whether the divisor fits.
    always_comb begin
        mulSum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        divShift = {hi_q, lo_q[WIDTH-1]};
        divDiff  = divShift - {1'b0, opnd_q};
        divFits  = ~divDiff[WIDTH];
        if (isDiv_q) begin
            stepHi = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            stepLo = {lo_q[WIDTH-2:0], divFits};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Control FSM with registered outputs. Flush beats both accept and out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            isDiv_q    <= 1'b0;
            result_q   <= '0;
            resultHi_q <= '0;
            dbz_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (isDivCmd && (val2 == '0)) begin
                            result_q   <= '1;
                            resultHi_q <= val1;
                            dbz_q      <= 1'b1;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else if (isMulCmd || isDivCmd) begin
                            hi_q    <= '0;
                            lo_q    <= val1;
                            opnd_q  <= val2;
                            isDiv_q <= isDivCmd;
                            cnt_q   <= CW'(WIDTH);
                            state_q <= CALC;
                        end else begin
                            result_q   <= aluRes;
                            resultHi_q <= '0;
                            dbz_q      <= 1'b0;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= stepHi;
                    lo_q  <= stepLo;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q   <= stepLo;
                        resultHi_q <= stepHi;
                        dbz_q      <= 1'b0;
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
